// File: rtl/sensor_packet_spi_master.sv
// SPI master (mode 0, MSB first) that frames one 16-byte sensor packet per start request.
// A single down-counter times the lead, SCK half-periods, trail and gap intervals.
module sensor_packet_spi_master #(
    parameter int          CLK_DIV  = 4,
    parameter int          CS_LEAD  = 4,
    parameter int          CS_TRAIL = 4,
    parameter int          CS_GAP   = 8,
    parameter logic [7:0]  HEADER   = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] roll,
    input  logic [15:0] pitch,
    input  logic [15:0] yaw,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    input  logic        euler_valid,
    input  logic        gyro_valid,
    output logic        busy,
    output logic        done,
    output logic        cs_n,
    output logic        sck,
    output logic        sdo
);
    // state | meaning
    // IDLE  | waiting for start, cs_n high
    // LEAD  | cs_n low, sck low, before first bit
    // SHIFT | 128 bits, each CLK_DIV low then CLK_DIV high
    // TRAIL | cs_n low after last sck fall
    // GAP   | cs_n high, still busy, start ignored

    localparam int MAX_A = (CLK_DIV > CS_LEAD) ? CLK_DIV : CS_LEAD;
    localparam int MAX_B = (CS_TRAIL > CS_GAP) ? CS_TRAIL : CS_GAP;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [6:0]         bit_cnt, bit_cnt_nx;
    logic [127:0]       pkt_buf, pkt_buf_nx;
    logic               busy_nx, done_nx, cs_n_nx, sck_nx, sdo_nx;
    logic [127:0]       pkt_in;

    assign pkt_in = {HEADER, roll, pitch, yaw, gyro_x, gyro_y, gyro_z,
                     6'b0, gyro_valid, euler_valid, 16'h0000};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            pkt_buf <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            sck     <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_cnt_nx;
            pkt_buf <= pkt_buf_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            cs_n    <= cs_n_nx;
            sck     <= sck_nx;
            sdo     <= sdo_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        bit_cnt_nx = bit_cnt;
        pkt_buf_nx = pkt_buf;
        busy_nx    = busy;
        done_nx    = 1'b0;
        cs_n_nx    = cs_n;
        sck_nx     = sck;
        sdo_nx     = sdo;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx   = LEAD;
                    cnt_nx     = CNT_W'(CS_LEAD - 1);
                    pkt_buf_nx = pkt_in;
                    busy_nx    = 1'b1;
                    cs_n_nx    = 1'b0;
                    sdo_nx     = pkt_in[127];
                end
            end
            LEAD: begin
                if (cnt == '0) begin
                    state_nx   = SHIFT;
                    cnt_nx     = CNT_W'(CLK_DIV - 1);
                    bit_cnt_nx = 7'd127;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    cnt_nx = CNT_W'(CLK_DIV - 1);
                    if (!sck) begin
                        sck_nx = 1'b1;
                    end else begin
                        sck_nx = 1'b0;
                        if (bit_cnt == 7'd0) begin
                            state_nx = TRAIL;
                            cnt_nx   = CNT_W'(CS_TRAIL - 1);
                            sdo_nx   = 1'b0;
                        end else begin
                            // sdo moves on the falling edge so it is settled well before the next rise
                            bit_cnt_nx = bit_cnt - 7'd1;
                            sdo_nx     = pkt_buf[bit_cnt - 7'd1];
                        end
                    end
                end
            end
            TRAIL: begin
                if (cnt == '0) begin
                    state_nx = GAP;
                    cnt_nx   = CNT_W'(CS_GAP - 1);
                    cs_n_nx  = 1'b1;
                    done_nx  = 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sensor_packet_spi_master.sv
// Self-checking bench for sensor_packet_spi_master: a bench-side SPI slave captures bits on sck
// rise and compares them with a byte-level packet model, alongside frame timing and busy/done checks.
module tb_sensor_packet_spi_master;
    localparam int CLK_DIV  = 4;
    localparam int CS_LEAD  = 4;
    localparam int CS_TRAIL = 4;
    localparam int CS_GAP   = 8;
    localparam int CS_LOW   = CS_LEAD + 256 * CLK_DIV + CS_TRAIL;
    localparam int RUN_LEN  = CS_LOW + CS_GAP + 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] roll, pitch, yaw, gyro_x, gyro_y, gyro_z;
    logic        euler_valid, gyro_valid;
    logic        busy, done, cs_n, sck, sdo;

    int n_total = 0;
    int n_pass  = 0;

    // observations of the most recent packet
    logic [7:0] rx_bytes [16];
    logic [7:0] exp_bytes [16];
    int rise_cnt, rise_err, cs_low_cnt, busy_cnt, done_cnt, done_idx, cs_rise_idx, first_rise, stray_edges;

    sensor_packet_spi_master #(
        .CLK_DIV(CLK_DIV), .CS_LEAD(CS_LEAD), .CS_TRAIL(CS_TRAIL), .CS_GAP(CS_GAP), .HEADER(8'hAA)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .roll(roll), .pitch(pitch), .yaw(yaw),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .euler_valid(euler_valid), .gyro_valid(gyro_valid),
        .busy(busy), .done(done), .cs_n(cs_n), .sck(sck), .sdo(sdo)
    );

    always #5 clk = ~clk;

    task automatic build_expected(input logic [15:0] r, p, y, gx, gy, gz, input logic ev, gv);
        exp_bytes = '{8'hAA, r[15:8], r[7:0], p[15:8], p[7:0], y[15:8], y[7:0],
                      gx[15:8], gx[7:0], gy[15:8], gy[7:0], gz[15:8], gz[7:0],
                      {6'b0, gv, ev}, 8'h00, 8'h00};
    endtask

    // mode 0: plain packet, 1: extra start pulses while busy, 2: roll changes after start
    task automatic run_packet(input logic [15:0] r, p, y, gx, gy, gz, input logic ev, gv, input int mode);
        logic prev_sck;
        int   nbits;
        build_expected(r, p, y, gx, gy, gz, ev, gv);
        @(negedge clk);
        roll = r; pitch = p; yaw = y; gyro_x = gx; gyro_y = gy; gyro_z = gz;
        euler_valid = ev; gyro_valid = gv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (rx_bytes[i]) rx_bytes[i] = 8'h00;
        rise_cnt = 0; rise_err = 0; cs_low_cnt = 0; busy_cnt = 0; done_cnt = 0;
        done_idx = -1; cs_rise_idx = -1; first_rise = -1; stray_edges = 0;
        prev_sck = 1'b0; nbits = 0;
        for (int idx = 0; idx < RUN_LEN; idx++) begin
            if (cs_n == 1'b0) cs_low_cnt++;
            else if (idx > 0 && cs_rise_idx < 0) cs_rise_idx = idx;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = idx;
            end
            if (sck != prev_sck) begin
                if (cs_n) stray_edges++;
                if (sck) begin
                    if (first_rise < 0) first_rise = idx;
                    if (idx != CS_LEAD + CLK_DIV + 2 * CLK_DIV * rise_cnt) rise_err++;
                    if (nbits < 128) rx_bytes[nbits / 8] = {rx_bytes[nbits / 8][6:0], sdo};
                    nbits++;
                    rise_cnt++;
                end else if (idx != CS_LEAD + 2 * CLK_DIV * rise_cnt) begin
                    rise_err++;
                end
            end
            prev_sck = sck;
            start = 1'b0;
            if (mode == 2 && idx == 0) roll = 16'hAAAA;
            if (mode == 1 && idx == 100) start = 1'b1;
            if (mode == 1 && done && done_cnt == 1) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_bytes(input string name);
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (rx_bytes[i] !== exp_bytes[i])
                $display("FAIL %s byte%0d: got %h want %h", name, i, rx_bytes[i], exp_bytes[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        int dones, cs_lows;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({cs_n, sck, sdo, busy, done} !== 5'b10000)
            $display("FAIL reset_values: got cs_n/sck/sdo/busy/done=%b want 10000", {cs_n, sck, sdo, busy, done});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        roll = 16'hFFFF; pitch = 16'hFFFF; yaw = 16'hFFFF;
        gyro_x = 16'hFFFF; gyro_y = 16'hFFFF; gyro_z = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        n_total++;
        if ({cs_n, busy} !== 2'b01)
            $display("FAIL mid_packet: got cs_n/busy=%b want 01", {cs_n, busy});
        else n_pass++;
        #2 reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({cs_n, sck, sdo, busy, done} !== 5'b10000)
            $display("FAIL abort_values: got cs_n/sck/sdo/busy/done=%b want 10000", {cs_n, sck, sdo, busy, done});
        else n_pass++;
        reset = 1'b0;
        dones = 0; cs_lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
            if (!cs_n || sck || busy) cs_lows++;
        end
        n_total++;
        if (dones !== 0 || cs_lows !== 0)
            $display("FAIL abort_quiet: got dones=%0d activity=%0d want 0 0", dones, cs_lows);
        else n_pass++;
    endtask

    task automatic test_frame_timing();
        run_packet(16'h1234, 16'hFEDC, 16'h0001, 16'h8000, 16'h7FFF, 16'h00FF, 1'b1, 1'b1, 0);
        check_bytes("frame");
        n_total++;
        if (cs_low_cnt !== CS_LOW) $display("FAIL cs_low: got %0d want %0d", cs_low_cnt, CS_LOW);
        else n_pass++;
        n_total++;
        if (rise_cnt !== 128) $display("FAIL sck_rises: got %0d want 128", rise_cnt);
        else n_pass++;
        n_total++;
        if (first_rise !== CS_LEAD + CLK_DIV) $display("FAIL first_rise: got %0d want %0d", first_rise, CS_LEAD + CLK_DIV);
        else n_pass++;
        n_total++;
        if (rise_err !== 0) $display("FAIL sck_phases: got %0d bad edges want 0", rise_err);
        else n_pass++;
        n_total++;
        if (stray_edges !== 0) $display("FAIL stray_sck: got %0d want 0", stray_edges);
        else n_pass++;
        n_total++;
        if (done_idx !== CS_LOW || cs_rise_idx !== CS_LOW)
            $display("FAIL done_align: got done=%0d cs_rise=%0d want %0d", done_idx, cs_rise_idx, CS_LOW);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL done_count: got %0d want 1", done_cnt);
        else n_pass++;
        n_total++;
        if (busy_cnt !== CS_LOW + CS_GAP) $display("FAIL busy_len: got %0d want %0d", busy_cnt, CS_LOW + CS_GAP);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        run_packet(16'h0F0F, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 1'b0, 1'b1, 1);
        check_bytes("ignore");
        n_total++;
        if (busy_cnt !== CS_LOW + CS_GAP) $display("FAIL ignore_busy: got %0d want %0d", busy_cnt, CS_LOW + CS_GAP);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL ignore_done: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_latch();
        run_packet(16'h1234, 16'hFEDC, 16'h0001, 16'h8000, 16'h7FFF, 16'h00FF, 1'b1, 1'b0, 2);
        check_bytes("latch");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            run_packet(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                       16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
            check_bytes("random");
            n_total++;
            if (cs_low_cnt !== CS_LOW) $display("FAIL random_cs_low: got %0d want %0d", cs_low_cnt, CS_LOW);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        roll = '0; pitch = '0; yaw = '0; gyro_x = '0; gyro_y = '0; gyro_z = '0;
        euler_valid = 1'b0; gyro_valid = 1'b0;
        test_reset();
        test_frame_timing();
        test_busy_ignore();
        test_latch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
